// File: rtl/qed_dup_encoder.sv
// qed_dup_encoder: passes IFU instructions to the core and replays buffered duplicable ones as QED duplicates.
// Optional QED_AUTO_DRAIN_EN: a push that fills the FIFO starts a drain without dup_trigger.
module qed_dup_encoder #(
   parameter int          DEPTH      = 8,
   parameter logic [11:0] MEM_OFFSET = 12'h400,
   parameter int          CW         = $clog2(DEPTH + 1)
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic          qed_mode,
   input  logic          dup_trigger,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [31:0]   in_instr,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_instr,
   output logic          out_is_dup,
   output logic [CW-1:0] fifo_count,
   output logic          draining,
   output logic          illegal_orig
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LW    = 7'b0000011;
   localparam logic [6:0] OP_SW    = 7'b0100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [0:0] S_ORIG   = 1'b0;
   localparam logic [0:0] S_DRAIN  = 1'b1;

   logic [0:0]    r_state;
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr, r_rd;
   logic [CW-1:0] r_count;
   logic          r_valid, r_is_dup, r_ill;
   logic [31:0]   r_instr;
   logic [6:0]    w_op;
   logic          w_use_rd, w_use_rs1, w_use_rs2, w_dupable, w_ill;
   logic          w_out_load, w_full, w_accept, w_push, w_pop, w_go_drain;
   logic [CW-1:0] w_count_next;

   // Used register fields move into the shadow bank x16..x31; x0 stays x0.
   function automatic logic [4:0] f_sh(input logic [4:0] r);
      return (r == 5'd0) ? 5'd0 : (r | 5'b10000);
   endfunction

   function automatic logic [31:0] f_enc(input logic [31:0] x);
      logic [11:0] s;
      logic [11:0] l;
      s = {x[31:25], x[11:7]} + MEM_OFFSET;
      l = x[31:20] + MEM_OFFSET;
      case (x[6:0])
         OP_R:     f_enc = {x[31:25], f_sh(x[24:20]), f_sh(x[19:15]), x[14:12], f_sh(x[11:7]), x[6:0]};
         OP_I:     f_enc = {x[31:20], f_sh(x[19:15]), x[14:12], f_sh(x[11:7]), x[6:0]};
         OP_LW:    f_enc = {l, f_sh(x[19:15]), x[14:12], f_sh(x[11:7]), x[6:0]};
         OP_SW:    f_enc = {s[11:5], f_sh(x[24:20]), f_sh(x[19:15]), x[14:12], s[4:0], x[6:0]};
         OP_LUI,
         OP_AUIPC: f_enc = {x[31:12], f_sh(x[11:7]), x[6:0]};
         default:  f_enc = x;
      endcase
   endfunction

   assign w_op      = in_instr[6:0];
   assign w_use_rs2 = (w_op == OP_R) || (w_op == OP_SW);
   assign w_use_rs1 = w_use_rs2 || (w_op == OP_I) || (w_op == OP_LW);
   assign w_use_rd  = (w_op == OP_R) || (w_op == OP_I) || (w_op == OP_LW) || (w_op == OP_LUI) || (w_op == OP_AUIPC);
   assign w_dupable = w_use_rd || w_use_rs1;
   assign w_ill     = (w_use_rd && in_instr[11]) || (w_use_rs1 && in_instr[19]) || (w_use_rs2 && in_instr[24]);

   assign w_out_load   = !r_valid || out_ready;
   assign w_full       = r_count == CW'(DEPTH);
   assign in_ready     = (r_state == S_ORIG) && w_out_load && !(qed_mode && w_dupable && w_full);
   assign w_accept     = in_valid && in_ready;
   assign w_push       = w_accept && qed_mode && w_dupable;
   assign w_pop        = (r_state == S_DRAIN) && w_out_load;
   assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

`ifdef QED_AUTO_DRAIN_EN
   assign w_go_drain = (dup_trigger || (w_push && w_count_next == CW'(DEPTH))) && (w_count_next != '0);
`else
   assign w_go_drain = dup_trigger && (w_count_next != '0);
`endif

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_state  <= S_ORIG;
         r_wr     <= '0;
         r_rd     <= '0;
         r_count  <= '0;
         r_valid  <= 1'b0;
         r_instr  <= '0;
         r_is_dup <= 1'b0;
         r_ill    <= 1'b0;
      end else begin
         if (w_push) r_wr <= r_wr + AW'(1);
         if (w_pop) r_rd <= r_rd + AW'(1);
         r_count <= w_count_next;
         r_state <= (r_state == S_ORIG) ? (w_go_drain ? S_DRAIN : S_ORIG)
                                        : ((w_pop && r_count == CW'(1)) ? S_ORIG : S_DRAIN);
         if (w_accept) begin
            r_instr  <= in_instr;
            r_is_dup <= 1'b0;
            r_valid  <= 1'b1;
         end else if (w_pop) begin
            r_instr  <= f_enc(r_mem[r_rd]);
            r_is_dup <= 1'b1;
            r_valid  <= 1'b1;
         end else if (out_ready) begin
            r_valid  <= 1'b0;
         end
         if (w_push && w_ill) r_ill <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (w_push) r_mem[r_wr] <= in_instr;
   end

   assign out_valid    = r_valid;
   assign out_instr    = r_instr;
   assign out_is_dup   = r_is_dup;
   assign fifo_count   = r_count;
   assign draining     = r_state == S_DRAIN;
   assign illegal_orig = r_ill;
endmodule

// File: tb/tb_qed_dup_encoder.sv
// tb_qed_dup_encoder: directed vector table plus hand sequences for fill, stall, illegal and reset corners.
module tb_qed_dup_encoder;
   logic        CLK = 1'b0;
   logic        RESET, qed_mode, dup_trigger, in_valid, out_ready;
   logic [31:0] in_instr;
   logic        in_ready, out_valid, out_is_dup, draining, illegal_orig;
   logic [31:0] out_instr;
   logic [3:0]  fifo_count;
   int          n_pass = 0;
   int          n_total = 0;

   typedef struct {
      logic [31:0] instr;
      logic        dupable;
      logic [31:0] enc;
   } vec_t;

   qed_dup_encoder dut (
      .CLK(CLK), .RESET(RESET), .qed_mode(qed_mode), .dup_trigger(dup_trigger),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
      .out_is_dup(out_is_dup), .fifo_count(fifo_count), .draining(draining),
      .illegal_orig(illegal_orig)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      qed_mode = 1'b0;
      dup_trigger = 1'b0;
      in_valid = 1'b0;
      in_instr = '0;
      out_ready = 1'b1;
      #7;
      RESET = 1'b0;
      step();
   endtask

   initial begin
      vec_t v[12];
      int   n;
      logic found;
      v[0]  = '{32'h002081B3, 1'b1, 32'h012889B3};
      v[1]  = '{32'h00832283, 1'b1, 32'h408B2A83};
      v[2]  = '{32'h00000013, 1'b1, 32'h00000013};
      v[3]  = '{32'h00208463, 1'b0, 32'h0};
      v[4]  = '{32'h0020A223, 1'b1, 32'h4128A223};
      v[5]  = '{32'h123453B7, 1'b1, 32'h12345BB7};
      v[6]  = '{32'h00000097, 1'b1, 32'h00000897};
      v[7]  = '{32'h00329213, 1'b1, 32'h003A9A13};
      v[8]  = '{32'h000000EF, 1'b0, 32'h0};
      v[9]  = '{32'h00000073, 1'b0, 32'h0};
      v[10] = '{32'hFFF12083, 1'b1, 32'h3FF92883};
      v[11] = '{32'h00000033, 1'b1, 32'h00000033};

      RESET = 1'b1; qed_mode = 1'b0; dup_trigger = 1'b0;
      in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
      #2;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_is_dup", 32'(out_is_dup), 0);
      chk("rst_fifo_count", 32'(fifo_count), 0);
      chk("rst_draining", 32'(draining), 0);
      chk("rst_illegal", 32'(illegal_orig), 0);
      do_reset();

      for (int i = 0; i < 12; i++) begin
         qed_mode = 1'b1;
         in_valid = 1'b1;
         in_instr = v[i].instr;
         step();
         in_valid = 1'b0;
         chk($sformatf("v%0d_orig_valid", i), 32'(out_valid), 1);
         chk($sformatf("v%0d_orig_instr", i), out_instr, v[i].instr);
         chk($sformatf("v%0d_orig_is_dup", i), 32'(out_is_dup), 0);
         chk($sformatf("v%0d_count", i), 32'(fifo_count), 32'(v[i].dupable));
         dup_trigger = 1'b1;
         step();
         dup_trigger = 1'b0;
         chk($sformatf("v%0d_draining", i), 32'(draining), 32'(v[i].dupable));
         step();
         if (v[i].dupable) begin
            chk($sformatf("v%0d_dup_instr", i), out_instr, v[i].enc);
            chk($sformatf("v%0d_dup_flag", i), 32'(out_is_dup), 1);
            chk($sformatf("v%0d_dup_valid", i), 32'(out_valid), 1);
         end
         chk($sformatf("v%0d_drained", i), 32'(draining), 0);
         chk($sformatf("v%0d_empty", i), 32'(fifo_count), 0);
      end
      chk("legal_no_illegal", 32'(illegal_orig), 0);

      qed_mode = 1'b0;
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      step();
      in_valid = 1'b0;
      chk("pass_instr", out_instr, 32'h002081B3);
      chk("pass_no_push", 32'(fifo_count), 0);

      do_reset();
      qed_mode = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         in_valid = 1'b1;
         in_instr = (k << 20) | 32'h93;
         step();
      end
      in_instr = 32'h00900093;
      chk("full_count", 32'(fifo_count), 8);
`ifdef QED_AUTO_DRAIN_EN
      chk("auto_drain", 32'(draining), 1);
`else
      for (int c = 0; c < 3; c++) begin
         step();
         chk("full_in_ready", 32'(in_ready), 0);
         chk("full_hold", 32'(fifo_count), 8);
      end
      in_instr = 32'h00208463;
      #1;
      chk("full_branch_ready", 32'(in_ready), 1);
      in_instr = 32'h00900093;
      dup_trigger = 1'b1;
      step();
      dup_trigger = 1'b0;
`endif
      n = 0;
      for (int c = 0; c < 30 && n < 8; c++) begin
         step();
         if (out_valid && out_is_dup) begin
            chk($sformatf("full_dup%0d", n), out_instr, ((n + 1) << 20) | 32'h893);
            n++;
         end
      end
      chk("full_dup_count", n, 8);
      found = 1'b0;
      for (int c = 0; c < 5 && !found; c++) begin
         step();
         if (out_valid && !out_is_dup) found = 1'b1;
      end
      in_valid = 1'b0;
      chk("ninth_accepted", 32'(found), 1);
      chk("ninth_instr", out_instr, 32'h00900093);
      chk("ninth_count", 32'(fifo_count), 1);

      do_reset();
      qed_mode = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h00108893;
      step();
      chk("illegal_set", 32'(illegal_orig), 1);
      in_instr = 32'h002081B3;
      step();
      in_valid = 1'b0;
      chk("illegal_enqueued", 32'(fifo_count), 2);
      dup_trigger = 1'b1;
      step();
      dup_trigger = 1'b0;
      step();
      chk("stall_first_dup", out_instr, 32'h00188893);
      chk("stall_first_flag", 32'(out_is_dup), 1);
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         step();
         chk("stall_instr", out_instr, 32'h00188893);
         chk("stall_valid", 32'(out_valid), 1);
         chk("stall_count", 32'(fifo_count), 1);
      end
      out_ready = 1'b1;
      step();
      chk("stall_second_dup", out_instr, 32'h012889B3);
      chk("stall_done", 32'(draining), 0);
      chk("stall_empty", 32'(fifo_count), 0);
      step();
      step();
      chk("illegal_sticky", 32'(illegal_orig), 1);

      do_reset();
      qed_mode = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h002081B3; step();
      in_instr = 32'h00832283; step();
      in_instr = 32'h00000013; step();
      in_valid = 1'b0;
      out_ready = 1'b0;
      dup_trigger = 1'b1;
      step();
      dup_trigger = 1'b0;
      chk("mid_draining", 32'(draining), 1);
      chk("mid_count", 32'(fifo_count), 3);
      chk("mid_valid_held", 32'(out_valid), 1);
      #2;
      RESET = 1'b1;
      #1;
      chk("async_valid", 32'(out_valid), 0);
      chk("async_count", 32'(fifo_count), 0);
      chk("async_draining", 32'(draining), 0);
      chk("async_instr", out_instr, 0);
      #1;
      RESET = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b1;
      in_instr = 32'h002081B3;
      step();
      in_valid = 1'b0;
      chk("post_rst_valid", 32'(out_valid), 1);
      chk("post_rst_is_dup", 32'(out_is_dup), 0);
      chk("post_rst_instr", out_instr, 32'h002081B3);
      chk("post_rst_count", 32'(fifo_count), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
